// File: rtl/sd_xfer_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : sd_xfer_ctrl
//  Purpose  : Single-block SD transfer sequencer. Issues CMD17 (read) or
//             CMD24 (write), checks the R1 card status, runs the D[3:0]
//             data phase and reports one completion code per request.
//             Write commands are retried after a response CRC failure or a
//             command timeout; read commands are never retried.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    iclk, irst            : 36 MHz system clock, synchronous active-high reset
//    istart                : transfer request pulse (honoured only when idle)
//    iwrite, iblock_addr   : direction (1 = write) and block address, latched
//                            on an accepted istart
//    obusy                 : cycle after accepted istart .. odone cycle
//    odone, oerr[2:0]      : completion pulse and code (code held until the
//                            next accepted istart)
//                            0 OK, 1 cmd timeout, 2 cmd CRC, 3 card status,
//                            4 data timeout, 5 data CRC
//    ocmd_start            : command start level to the transceiver
//    ocmd_index, ocmd_arg  : command index (17/24) and argument (address)
//    olong_resp            : R2 select, constant 0
//    icmd_done             : command done level (rising edge is the event)
//    icmd_crc_fail, iresp  : response CRC flag and R1 status, taken at the
//                            icmd_done rising edge
//    odata_start           : data start level to the transceiver
//    idata_done            : data done level (rising edge is the event)
//    idata_crc_fail        : data CRC flag, taken at the idata_done rising edge
// ============================================================================
module sd_xfer_ctrl #(
    parameter int unsigned CMD_TO    = 65535,
    parameter int unsigned DATA_TO   = 3600000,
    parameter int unsigned MAX_RETRY = 2
) (
    input  logic        iclk,
    input  logic        irst,
    input  logic        istart,
    input  logic        iwrite,
    input  logic [31:0] iblock_addr,
    output logic        obusy,
    output logic        odone,
    output logic [2:0]  oerr,
    output logic        ocmd_start,
    output logic [5:0]  ocmd_index,
    output logic [31:0] ocmd_arg,
    output logic        olong_resp,
    input  logic        icmd_done,
    input  logic        icmd_crc_fail,
    input  logic [31:0] iresp,
    output logic        odata_start,
    input  logic        idata_done,
    input  logic        idata_crc_fail
);

    localparam int unsigned TIMER_W = 22;
    localparam int unsigned RETRY_W = $clog2(MAX_RETRY + 2);

    localparam logic [TIMER_W-1:0] C_CMD_TO    = CMD_TO[TIMER_W-1:0];
    localparam logic [TIMER_W-1:0] C_DATA_TO   = DATA_TO[TIMER_W-1:0];
    localparam logic [RETRY_W-1:0] C_MAX_RETRY = MAX_RETRY[RETRY_W-1:0];

    localparam logic [5:0] C_IDX_READ  = 6'd17;
    localparam logic [5:0] C_IDX_WRITE = 6'd24;

    localparam logic [2:0] C_ERR_OK       = 3'd0;
    localparam logic [2:0] C_ERR_CMD_TO   = 3'd1;
    localparam logic [2:0] C_ERR_CMD_CRC  = 3'd2;
    localparam logic [2:0] C_ERR_STATUS   = 3'd3;
    localparam logic [2:0] C_ERR_DATA_TO  = 3'd4;
    localparam logic [2:0] C_ERR_DATA_CRC = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CMD     = 3'd1,
        ST_CMD_GAP = 3'd2,
        ST_RESP    = 3'd3,
        ST_DATA    = 3'd4,
        ST_FIN     = 3'd5
    } state_t;

    state_t               state_q, state_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [2:0]           err_q, err_d;
    logic                 cmd_start_q, cmd_start_d;
    logic                 data_start_q, data_start_d;
    logic [5:0]           cmd_index_q, cmd_index_d;
    logic [31:0]          cmd_arg_q, cmd_arg_d;
    logic                 write_q, write_d;
    logic [RETRY_W-1:0]   retry_q, retry_d;
    logic [TIMER_W-1:0]   timer_q, timer_d;
    logic                 resp_err_q, resp_err_d;
    logic                 cmd_done_q, data_done_q;

    logic                 w_cmd_edge;
    logic                 w_data_edge;
    logic                 w_cmd_to;
    logic                 w_data_to;
    logic [TIMER_W-1:0]   w_timer_inc;
    logic                 w_unused_resp;

    // Done levels come from the slow transceiver domain; only the rising
    // edge against the registered copy counts as an event.
    assign w_cmd_edge  = icmd_done  & ~cmd_done_q;
    assign w_data_edge = idata_done & ~data_done_q;

    assign w_cmd_to    = (timer_q >= C_CMD_TO);
    assign w_data_to   = (timer_q >= C_DATA_TO);
    assign w_timer_inc = (timer_q == {TIMER_W{1'b1}}) ? timer_q : timer_q + 1'b1;

    // Only the R1 error bits [31:19] matter; the state bits are ignored.
    assign w_unused_resp = ^iresp[18:0];

    always_comb begin
        state_d      = state_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        err_d        = err_q;
        cmd_start_d  = cmd_start_q;
        data_start_d = data_start_q;
        cmd_index_d  = cmd_index_q;
        cmd_arg_d    = cmd_arg_q;
        write_d      = write_q;
        retry_d      = retry_q;
        timer_d      = timer_q;
        resp_err_d   = resp_err_q;

        case (state_q)
            ST_IDLE: begin
                busy_d       = 1'b0;
                cmd_start_d  = 1'b0;
                data_start_d = 1'b0;
                if (istart) begin
                    write_d     = iwrite;
                    cmd_index_d = iwrite ? C_IDX_WRITE : C_IDX_READ;
                    cmd_arg_d   = iblock_addr;
                    retry_d     = '0;
                    timer_d     = '0;
                    err_d       = C_ERR_OK;
                    busy_d      = 1'b1;
                    state_d     = ST_CMD;
                end
            end

            ST_CMD: begin
                timer_d = w_timer_inc;
                if (w_cmd_edge) begin
                    resp_err_d = |iresp[31:19];
                end
                // A done edge beats a timeout reached in the same cycle.
                if (w_cmd_edge && !icmd_crc_fail) begin
                    cmd_start_d  = 1'b0;
                    data_start_d = ~write_q;
                    state_d      = ST_RESP;
                end else if (w_cmd_edge || w_cmd_to) begin
                    cmd_start_d = 1'b0;
                    if (write_q && (retry_q < C_MAX_RETRY)) begin
                        retry_d = retry_q + 1'b1;
                        timer_d = '0;
                        state_d = ST_CMD_GAP;
                    end else begin
                        data_start_d = 1'b0;
                        err_d        = w_cmd_edge ? C_ERR_CMD_CRC : C_ERR_CMD_TO;
                        done_d       = 1'b1;
                        state_d      = ST_FIN;
                    end
                end else begin
                    // Reads arm the data receiver together with the command
                    // so the block cannot arrive before it is listening.
                    cmd_start_d  = 1'b1;
                    data_start_d = ~write_q;
                end
            end

            ST_CMD_GAP: begin
                // Re-raise the start level on the way back into CMD so the
                // line is low for exactly one cycle between attempts.
                cmd_start_d = 1'b1;
                timer_d     = '0;
                state_d     = ST_CMD;
            end

            ST_RESP: begin
                if (resp_err_q) begin
                    data_start_d = 1'b0;
                    err_d        = C_ERR_STATUS;
                    done_d       = 1'b1;
                    state_d      = ST_FIN;
                end else begin
                    data_start_d = 1'b1;
                    timer_d      = '0;
                    state_d      = ST_DATA;
                end
            end

            ST_DATA: begin
                timer_d = w_timer_inc;
                if (w_data_edge) begin
                    data_start_d = 1'b0;
                    err_d        = idata_crc_fail ? C_ERR_DATA_CRC : C_ERR_OK;
                    done_d       = 1'b1;
                    state_d      = ST_FIN;
                end else if (w_data_to) begin
                    data_start_d = 1'b0;
                    err_d        = C_ERR_DATA_TO;
                    done_d       = 1'b1;
                    state_d      = ST_FIN;
                end else begin
                    data_start_d = 1'b1;
                end
            end

            ST_FIN: begin
                // odone is high during this cycle; obusy drops after it.
                busy_d       = 1'b0;
                cmd_start_d  = 1'b0;
                data_start_d = 1'b0;
                state_d      = ST_IDLE;
            end

            default: begin
                busy_d       = 1'b0;
                cmd_start_d  = 1'b0;
                data_start_d = 1'b0;
                state_d      = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge iclk) begin
        if (irst) begin
            state_q      <= ST_IDLE;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= C_ERR_OK;
            cmd_start_q  <= 1'b0;
            data_start_q <= 1'b0;
            cmd_index_q  <= 6'd0;
            cmd_arg_q    <= 32'd0;
            write_q      <= 1'b0;
            retry_q      <= '0;
            timer_q      <= '0;
            resp_err_q   <= 1'b0;
            cmd_done_q   <= 1'b0;
            data_done_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
            cmd_start_q  <= cmd_start_d;
            data_start_q <= data_start_d;
            cmd_index_q  <= cmd_index_d;
            cmd_arg_q    <= cmd_arg_d;
            write_q      <= write_d;
            retry_q      <= retry_d;
            timer_q      <= timer_d;
            resp_err_q   <= resp_err_d;
            cmd_done_q   <= icmd_done;
            data_done_q  <= idata_done;
        end
    end

    assign obusy       = busy_q;
    assign odone       = done_q;
    assign oerr        = err_q;
    assign ocmd_start  = cmd_start_q;
    assign odata_start = data_start_q;
    assign ocmd_index  = cmd_index_q;
    assign ocmd_arg    = cmd_arg_q;
    assign olong_resp  = 1'b0;

endmodule
`default_nettype wire
